pipe_sequencer: RTL and testbench

Central pipeline-control block for the 5-stage core. It resolves EX-stage branches from the branch-select code and ALU flags, and drives pc_select. It sequences stage enables and flushes for taken branches, load-use stalls, multi-cycle data-memory waits and halt. Sits beside the hazard-detection logic, feeding the PC mux and the IF/ID, ID/EX and EX/MEM pipe registers.

---
 rtl/pipe_ctrl_pkg.sv | 33 +++
 rtl/pipe_sequencer_sat_counter.sv | 23 ++
 rtl/pipe_sequencer.sv | 157 +++++++++++++++
 tb/tb_pipe_sequencer.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and encodings for the pipeline sequencer: FSM states,
// EX-stage branch-select codes and ALU flag bit positions.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        BR_FLUSH = 2'd1,
        MEM_WAIT = 2'd2,
        HALTED   = 2'd3
    } state_t;

    localparam logic [1:0] BR_NONE = 2'b00;
    localparam logic [1:0] BR_JUMP = 2'b01;
    localparam logic [1:0] BR_ZERO = 2'b10;
    localparam logic [1:0] BR_NEG  = 2'b11;

    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 0;

    function automatic logic branch_taken(input logic [1:0] sel, input logic [1:0] flags);
        logic taken;
        taken = 1'b0;
        case (sel)
            BR_NONE: taken = 1'b0;
            BR_JUMP: taken = 1'b1;
            BR_ZERO: taken = flags[FLAG_Z];
            BR_NEG:  taken = flags[FLAG_N];
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/pipe_sequencer_sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            count_reg <= '0;
        end else if (inc_i && (count_reg != '1)) begin
            count_reg <= count_reg + WIDTH'(1);
        end
    end

    assign count_o = count_reg;

endmodule

// File: rtl/pipe_sequencer.sv
// Pipeline sequencer: resolves EX branches and drives PC select, stage
// enables and flushes for branches, load-use stalls, memory waits and halt.
module pipe_sequencer
    import pipe_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int MEM_TIMEOUT  = 64,
    parameter int CNT_W        = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [1:0]       branchselect_ex_i,
    input  logic [1:0]       alu_flags_i,
    input  logic             load_use_i,
    input  logic             mem_busy_i,
    input  logic             halt_i,
    output logic             pc_select_o,
    output logic             pc_en_o,
    output logic             if_id_en_o,
    output logic             id_ex_en_o,
    output logic             ex_mem_en_o,
    output logic             flush_if_id_o,
    output logic             flush_id_ex_o,
    output logic             halted_o,
    output logic             fault_o,
    output logic [CNT_W-1:0] branch_cnt_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam logic [2:0] FLUSH_INIT   = 3'(FLUSH_CYCLES - 1);
    localparam logic [7:0] TIMEOUT_CYCS = 8'(MEM_TIMEOUT);

    state_t     state_reg, state_next;
    logic [2:0] rem_reg, rem_next;
    logic [7:0] wait_reg, wait_next;
    logic       fault_reg, fault_next;
    logic       taken;
    logic       branch_inc;
    logic       stall_inc;

    assign taken = branch_taken(branchselect_ex_i, alu_flags_i);

    always_comb begin
        state_next    = state_reg;
        rem_next      = rem_reg;
        wait_next     = wait_reg;
        fault_next    = fault_reg;
        pc_select_o   = 1'b0;
        pc_en_o       = 1'b1;
        if_id_en_o    = 1'b1;
        id_ex_en_o    = 1'b1;
        ex_mem_en_o   = 1'b1;
        flush_if_id_o = 1'b0;
        flush_id_ex_o = 1'b0;
        halted_o      = 1'b0;
        branch_inc    = 1'b0;
        stall_inc     = 1'b0;

        case (state_reg)
            // The cycle busy drops in MEM_WAIT behaves exactly like RUN, so the
            // held EX instruction is resolved without losing a cycle.
            RUN, MEM_WAIT: begin
                if (mem_busy_i) begin
                    pc_en_o     = 1'b0;
                    if_id_en_o  = 1'b0;
                    id_ex_en_o  = 1'b0;
                    ex_mem_en_o = 1'b0;
                    stall_inc   = 1'b1;
                    if (state_reg == RUN) begin
                        state_next = MEM_WAIT;
                        wait_next  = 8'd1;
                    end else if (wait_reg + 8'd1 == TIMEOUT_CYCS) begin
                        state_next = HALTED;
                        fault_next = 1'b1;
                    end else begin
                        wait_next = wait_reg + 8'd1;
                    end
                end else if (taken) begin
                    pc_select_o   = 1'b1;
                    flush_if_id_o = 1'b1;
                    flush_id_ex_o = 1'b1;
                    branch_inc    = 1'b1;
                    rem_next      = FLUSH_INIT;
                    state_next    = (FLUSH_CYCLES > 1) ? BR_FLUSH : RUN;
                end else if (halt_i) begin
                    state_next = HALTED;
                end else if (load_use_i) begin
                    pc_en_o       = 1'b0;
                    if_id_en_o    = 1'b0;
                    flush_id_ex_o = 1'b1;
                    stall_inc     = 1'b1;
                    state_next    = RUN;
                end else begin
                    state_next = RUN;
                end
            end
            BR_FLUSH: begin
                flush_if_id_o = 1'b1;
                flush_id_ex_o = 1'b1;
                if (mem_busy_i) begin
                    pc_en_o     = 1'b0;
                    if_id_en_o  = 1'b0;
                    id_ex_en_o  = 1'b0;
                    ex_mem_en_o = 1'b0;
                    stall_inc   = 1'b1;
                end else begin
                    rem_next = rem_reg - 3'd1;
                    if (rem_reg == 3'd1) begin
                        state_next = RUN;
                    end
                end
            end
            HALTED: begin
                pc_en_o     = 1'b0;
                if_id_en_o  = 1'b0;
                id_ex_en_o  = 1'b0;
                ex_mem_en_o = 1'b0;
                halted_o    = 1'b1;
            end
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_reg <= RUN;
            rem_reg   <= 3'd0;
            wait_reg  <= 8'd0;
            fault_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            rem_reg   <= rem_next;
            wait_reg  <= wait_next;
            fault_reg <= fault_next;
        end
    end

    assign fault_o = fault_reg;

    logic [1:0]       cnt_inc;
    logic [CNT_W-1:0] cnt_val [2];

    assign cnt_inc = {stall_inc, branch_inc};

    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
        sat_counter #(.WIDTH(CNT_W)) u_cnt (
            .clk_i   (clk_i),
            .rst_n_i (rst_n_i),
            .inc_i   (cnt_inc[gi]),
            .count_o (cnt_val[gi])
        );
    end

    assign branch_cnt_o = cnt_val[0];
    assign stall_cnt_o  = cnt_val[1];

endmodule

// File: tb/tb_pipe_sequencer.sv
// Directed vector bench for pipe_sequencer (FLUSH_CYCLES=3, MEM_TIMEOUT=64).
module tb_pipe_sequencer;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic [1:0]  branchselect_ex_i;
    logic [1:0]  alu_flags_i;
    logic        load_use_i;
    logic        mem_busy_i;
    logic        halt_i;
    logic        pc_select_o, pc_en_o, if_id_en_o, id_ex_en_o, ex_mem_en_o;
    logic        flush_if_id_o, flush_id_ex_o, halted_o, fault_o;
    logic [15:0] branch_cnt_o, stall_cnt_o;

    always #5 clk_i = ~clk_i;

    pipe_sequencer #(
        .FLUSH_CYCLES (3),
        .MEM_TIMEOUT  (64),
        .CNT_W        (16)
    ) dut (
        .clk_i             (clk_i),
        .rst_n_i           (rst_n_i),
        .branchselect_ex_i (branchselect_ex_i),
        .alu_flags_i       (alu_flags_i),
        .load_use_i        (load_use_i),
        .mem_busy_i        (mem_busy_i),
        .halt_i            (halt_i),
        .pc_select_o       (pc_select_o),
        .pc_en_o           (pc_en_o),
        .if_id_en_o        (if_id_en_o),
        .id_ex_en_o        (id_ex_en_o),
        .ex_mem_en_o       (ex_mem_en_o),
        .flush_if_id_o     (flush_if_id_o),
        .flush_id_ex_o     (flush_id_ex_o),
        .halted_o          (halted_o),
        .fault_o           (fault_o),
        .branch_cnt_o      (branch_cnt_o),
        .stall_cnt_o       (stall_cnt_o)
    );

    // {pc_select, pc_en, if_id_en, id_ex_en, ex_mem_en, flush_if_id, flush_id_ex, halted, fault}
    localparam logic [8:0] C_IDLE    = 9'b0_1111_00_0_0;
    localparam logic [8:0] C_TAKEN   = 9'b1_1111_11_0_0;
    localparam logic [8:0] C_FLUSH   = 9'b0_1111_11_0_0;
    localparam logic [8:0] C_LU      = 9'b0_0011_01_0_0;
    localparam logic [8:0] C_STALL   = 9'b0_0000_00_0_0;
    localparam logic [8:0] C_FLSTALL = 9'b0_0000_11_0_0;
    localparam logic [8:0] C_HALT    = 9'b0_0000_00_1_0;
    localparam logic [8:0] C_FAULT   = 9'b0_0000_00_1_1;

    typedef struct {
        logic [1:0] ex;
        logic [1:0] fl;
        logic       lu;
        logic       busy;
        logic       halt;
        logic [8:0] ctl;
        int         b;
        int         s;
    } vec_t;

    vec_t tbl[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    function automatic vec_t mk(input logic [1:0] ex, input logic [1:0] fl, input logic lu,
                                input logic busy, input logic halt, input logic [8:0] ctl,
                                input int b, input int s);
        vec_t v;
        v.ex = ex; v.fl = fl; v.lu = lu; v.busy = busy; v.halt = halt;
        v.ctl = ctl; v.b = b; v.s = s;
        return v;
    endfunction

    task automatic check(input string tag, input logic [8:0] ctl, input int b, input int s);
        logic [8:0] act;
        act = {pc_select_o, pc_en_o, if_id_en_o, id_ex_en_o, ex_mem_en_o,
               flush_if_id_o, flush_id_ex_o, halted_o, fault_o};
        n_vec++;
        if (act !== ctl || branch_cnt_o !== 16'(b) || stall_cnt_o !== 16'(s)) begin
            n_miss++;
            $display("FAIL %s: ctl got %b want %b, branch_cnt got %0d want %0d, stall_cnt got %0d want %0d",
                     tag, act, ctl, branch_cnt_o, b, stall_cnt_o, s);
        end else begin
            $display("ok   %s: ex=%b fl=%b lu=%b busy=%b halt=%b ctl=%b bcnt=%0d scnt=%0d",
                     tag, branchselect_ex_i, alu_flags_i, load_use_i, mem_busy_i, halt_i,
                     act, branch_cnt_o, stall_cnt_o);
        end
    endtask

    task automatic apply(input vec_t v, input string tag);
        @(posedge clk_i);
        #1;
        branchselect_ex_i = v.ex;
        alu_flags_i       = v.fl;
        load_use_i        = v.lu;
        mem_busy_i        = v.busy;
        halt_i            = v.halt;
        @(negedge clk_i);
        check(tag, v.ctl, v.b, v.s);
    endtask

    task automatic do_reset();
        @(posedge clk_i);
        #1;
        rst_n_i = 1'b0;
        branchselect_ex_i = 2'b00; alu_flags_i = 2'b00;
        load_use_i = 1'b0; mem_busy_i = 1'b0; halt_i = 1'b0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_n_i = 1'b1;
    endtask

    initial begin
        rst_n_i = 1'b0;
        branchselect_ex_i = 2'b00; alu_flags_i = 2'b00;
        load_use_i = 1'b0; mem_busy_i = 1'b0; halt_i = 1'b0;

        //            ex     fl     lu    busy  halt  ctl        b  s
        tbl.push_back(mk(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, C_IDLE,    0, 0));
        tbl.push_back(mk(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, C_IDLE,    0, 0));
        tbl.push_back(mk(2'b10, 2'b10, 1'b0, 1'b0, 1'b0, C_TAKEN,   0, 0));
        tbl.push_back(mk(2'b01, 2'b00, 1'b0, 1'b0, 1'b0, C_FLUSH,   1, 0));
        tbl.push_back(mk(2'b01, 2'b00, 1'b0, 1'b0, 1'b0, C_FLUSH,   1, 0));
        tbl.push_back(mk(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, C_IDLE,    1, 0));
        tbl.push_back(mk(2'b11, 2'b10, 1'b0, 1'b0, 1'b0, C_IDLE,    1, 0));
        tbl.push_back(mk(2'b11, 2'b01, 1'b0, 1'b0, 1'b0, C_TAKEN,   1, 0));
        tbl.push_back(mk(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, C_FLUSH,   2, 0));
        tbl.push_back(mk(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, C_FLUSH,   2, 0));
        tbl.push_back(mk(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, C_IDLE,    2, 0));
        tbl.push_back(mk(2'b10, 2'b01, 1'b0, 1'b0, 1'b0, C_IDLE,    2, 0));
        tbl.push_back(mk(2'b00, 2'b11, 1'b0, 1'b0, 1'b0, C_IDLE,    2, 0));
        tbl.push_back(mk(2'b00, 2'b00, 1'b1, 1'b0, 1'b0, C_LU,      2, 0));
        tbl.push_back(mk(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, C_IDLE,    2, 1));
        tbl.push_back(mk(2'b01, 2'b00, 1'b1, 1'b0, 1'b0, C_TAKEN,   2, 1));
        tbl.push_back(mk(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, C_FLUSH,   3, 1));
        tbl.push_back(mk(2'b00, 2'b00, 1'b1, 1'b0, 1'b0, C_FLUSH,   3, 1));
        tbl.push_back(mk(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, C_IDLE,    3, 1));
        for (int k = 0; k < 5; k++)
            tbl.push_back(mk(2'b01, 2'b00, 1'b0, 1'b1, 1'b0, C_STALL, 3, 1 + k));
        tbl.push_back(mk(2'b01, 2'b00, 1'b0, 1'b0, 1'b0, C_TAKEN,   3, 6));
        tbl.push_back(mk(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, C_FLUSH,   4, 6));
        tbl.push_back(mk(2'b00, 2'b00, 1'b0, 1'b1, 1'b0, C_FLSTALL, 4, 6));
        tbl.push_back(mk(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, C_FLUSH,   4, 7));
        tbl.push_back(mk(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, C_IDLE,    4, 7));
        tbl.push_back(mk(2'b10, 2'b10, 1'b0, 1'b0, 1'b1, C_TAKEN,   4, 7));
        tbl.push_back(mk(2'b00, 2'b00, 1'b0, 1'b0, 1'b1, C_FLUSH,   5, 7));
        tbl.push_back(mk(2'b00, 2'b00, 1'b0, 1'b0, 1'b1, C_FLUSH,   5, 7));
        tbl.push_back(mk(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, C_IDLE,    5, 7));
        tbl.push_back(mk(2'b00, 2'b00, 1'b1, 1'b0, 1'b1, C_IDLE,    5, 7));
        tbl.push_back(mk(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, C_HALT,    5, 7));
        tbl.push_back(mk(2'b01, 2'b00, 1'b0, 1'b1, 1'b0, C_HALT,    5, 7));

        do_reset();
        for (int i = 0; i < tbl.size(); i++)
            apply(tbl[i], $sformatf("vec%0d", i));

        // Busy for one cycle less than the timeout: no fault, back to RUN.
        do_reset();
        for (int k = 0; k < 63; k++)
            apply(mk(2'b00, 2'b00, 1'b0, 1'b1, 1'b0, C_STALL, 0, k), $sformatf("busy63_%0d", k));
        apply(mk(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, C_IDLE, 0, 63), "busy63_done");

        // Busy for the full timeout: fault halt.
        for (int k = 0; k < 64; k++)
            apply(mk(2'b00, 2'b00, 1'b0, 1'b1, 1'b0, C_STALL, 0, 63 + k), $sformatf("busy64_%0d", k));
        apply(mk(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, C_FAULT, 0, 127), "timeout_fault");
        apply(mk(2'b01, 2'b00, 1'b0, 1'b0, 1'b0, C_FAULT, 0, 127), "fault_sticky");

        // Asynchronous reset mid-cycle from the faulted state.
        @(posedge clk_i);
        #1;
        branchselect_ex_i = 2'b00; mem_busy_i = 1'b0;
        #2;
        rst_n_i = 1'b0;
        #1;
        check("async_reset", C_IDLE, 0, 0);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        apply(mk(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, C_IDLE, 0, 0), "post_reset");
        apply(mk(2'b01, 2'b00, 1'b0, 1'b0, 1'b0, C_TAKEN, 0, 0), "post_reset_jump");
        apply(mk(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, C_FLUSH, 1, 0), "post_reset_flush");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
